// File: rtl/pong_pkg.sv
// Shared encodings and helpers for the Pong engine: game states, direction
// bits, the internal coordinate type and centring arithmetic.
package pong_pkg;

  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  typedef logic [1:0] game_state_t;
  localparam game_state_t ST_SERVE    = 2'd0;
  localparam game_state_t ST_PLAY     = 2'd1;
  localparam game_state_t ST_POINT    = 2'd2;
  localparam game_state_t ST_GAMEOVER = 2'd3;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // Top-left coordinate that centres an object of 'size' within 'span'.
  function automatic coord_t centre(input int span, input int size);
    return coord_t'((span - size) / 2);
  endfunction

  // Paddle-face x positions: left paddle inner edge and right paddle inner edge.
  function automatic coord_t left_face(input int margin, input int width);
    return coord_t'(margin + width);
  endfunction

  function automatic coord_t right_face(input int h_res, input int margin, input int width);
    return coord_t'(h_res - margin - width);
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle's vertical position: button-driven or auto-tracking, clamped to
// the playfield, updated only on frame ticks.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int V_RES        = 480,
  parameter int PADDLE_H     = 48,
  parameter int PADDLE_SPEED = 4,
  parameter int AUTO         = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   frame_tick,
  input  logic   enable,
  input  logic   recentre,
  input  logic   up,
  input  logic   dn,
  input  coord_t target,
  output coord_t pos
);

  localparam coord_t POS_MAX  = coord_t'(V_RES - PADDLE_H);
  localparam coord_t POS_INIT = centre(V_RES, PADDLE_H);
  localparam coord_t STEP     = coord_t'(PADDLE_SPEED);

  coord_t pos_nxt;

  always_comb begin
    pos_nxt = pos;
    if (AUTO != 0) begin
      // Step toward the target without overshooting it.
      if (target > pos) begin
        pos_nxt = (target - pos > STEP) ? pos + STEP : target;
      end else if (target < pos) begin
        pos_nxt = (pos - target > STEP) ? pos - STEP : target;
      end
      if (pos_nxt > POS_MAX) pos_nxt = POS_MAX;
    end else if (up && !dn) begin
      pos_nxt = (pos < STEP) ? '0 : pos - STEP;
    end else if (dn && !up) begin
      pos_nxt = (pos + STEP > POS_MAX) ? POS_MAX : pos + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= POS_INIT;
    end else if (frame_tick) begin
      if (recentre) pos <= POS_INIT;
      else if (enable) pos <= pos_nxt;
    end
  end

endmodule

// File: rtl/pong_engine.sv
// Two-paddle Pong engine: ball motion, serve/play/point/game-over sequencing,
// scores, and registered per-pixel ball/paddle masks.
module pong_engine
  import pong_pkg::*;
#(
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int BALL_SIZE     = 8,
  parameter int BALL_SPEED    = 2,
  parameter int PADDLE_H      = 48,
  parameter int PADDLE_W      = 8,
  parameter int PADDLE_MARGIN = 16,
  parameter int PADDLE_SPEED  = 4,
  parameter int SERVE_FRAMES  = 60,
  parameter int SCORE_W       = 4,
  parameter int WIN_SCORE     = 9,
  parameter int TWO_PLAYER    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               btn_l_up,
  input  logic               btn_l_dn,
  input  logic               btn_r_up,
  input  logic               btn_r_dn,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  output logic               pixel_ball,
  output logic               pixel_paddle,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         game_state
);

  localparam int CNT_W = (SERVE_FRAMES > 2) ? $clog2(SERVE_FRAMES) : 1;

  localparam coord_t BALL_X0   = centre(H_RES, BALL_SIZE);
  localparam coord_t BALL_Y0   = centre(V_RES, BALL_SIZE);
  localparam coord_t PE        = left_face(PADDLE_MARGIN, PADDLE_W);
  localparam coord_t PR        = right_face(H_RES, PADDLE_MARGIN, PADDLE_W);
  localparam coord_t PL_X      = coord_t'(PADDLE_MARGIN);
  localparam coord_t PAD_W     = coord_t'(PADDLE_W);
  localparam coord_t PAD_H     = coord_t'(PADDLE_H);
  localparam coord_t SIZE      = coord_t'(BALL_SIZE);
  localparam coord_t SPEED     = coord_t'(BALL_SPEED);
  localparam coord_t X_LIM     = coord_t'(H_RES);
  localparam coord_t Y_LIM     = coord_t'(V_RES);
  localparam coord_t HALF_BALL = coord_t'(BALL_SIZE / 2);
  localparam coord_t HALF_PAD  = coord_t'(PADDLE_H / 2);

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  game_state_t        state, state_n;
  coord_t             ball_x, ball_x_n, ball_y, ball_y_n;
  logic               dir_x, dir_x_n, dir_y, dir_y_n;
  logic [CNT_W-1:0]   serve_cnt, serve_cnt_n;
  logic [SCORE_W-1:0] score_l_n, score_r_n;
  logic               left_scored, left_scored_n;

  coord_t pad_l, pad_r, track_target, ball_cy;
  logic   any_btn, paddles_on, paddles_reset;
  logic   overlap_l, overlap_r, hit_l, hit_r, miss_l, miss_r;

  assign game_state = state;
  assign any_btn    = btn_l_up | btn_l_dn | btn_r_up | btn_r_dn;
  assign paddles_on    = (state != ST_GAMEOVER);
  assign paddles_reset = (state == ST_GAMEOVER) && any_btn;

  // Auto-track aims the paddle centre at the ball centre; clamping is in the paddle.
  assign ball_cy      = ball_y + HALF_BALL;
  assign track_target = (ball_cy < HALF_PAD) ? '0 : ball_cy - HALF_PAD;

  pong_paddle #(
    .V_RES(V_RES), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED), .AUTO(0)
  ) u_paddle_l (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(paddles_on),
    .recentre(paddles_reset), .up(btn_l_up), .dn(btn_l_dn),
    .target('0), .pos(pad_l)
  );

  pong_paddle #(
    .V_RES(V_RES), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED),
    .AUTO((TWO_PLAYER == 0) ? 1 : 0)
  ) u_paddle_r (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(paddles_on),
    .recentre(paddles_reset), .up(btn_r_up), .dn(btn_r_dn),
    .target(track_target), .pos(pad_r)
  );

  assign overlap_l = (ball_y < pad_l + PAD_H) && (ball_y + SIZE > pad_l);
  assign overlap_r = (ball_y < pad_r + PAD_H) && (ball_y + SIZE > pad_r);

  // ball_x < PE + SPEED is the underflow-free form of ball_x - SPEED < PE.
  assign hit_l  = (dir_x == DIR_LEFT) && (ball_x >= PE) && (ball_x < PE + SPEED) && overlap_l;
  assign hit_r  = (dir_x == DIR_RIGHT) && (ball_x + SIZE <= PR) &&
                  (ball_x + SIZE + SPEED > PR) && overlap_r;
  assign miss_l = (dir_x == DIR_LEFT) && (ball_x < SPEED);
  assign miss_r = (dir_x == DIR_RIGHT) && (ball_x + SIZE + SPEED > X_LIM);

  always_comb begin
    state_n       = state;
    ball_x_n      = ball_x;
    ball_y_n      = ball_y;
    dir_x_n       = dir_x;
    dir_y_n       = dir_y;
    serve_cnt_n   = serve_cnt;
    score_l_n     = score_l;
    score_r_n     = score_r;
    left_scored_n = left_scored;
    case (state)
      ST_SERVE: begin
        if (serve_cnt == SERVE_LAST) begin
          serve_cnt_n = '0;
          state_n     = ST_PLAY;
        end else begin
          serve_cnt_n = serve_cnt + CNT_ONE;
        end
      end
      ST_PLAY: begin
        if (dir_y == DIR_UP) begin
          if (ball_y < SPEED) begin
            ball_y_n = '0;
            dir_y_n  = DIR_DOWN;
          end else begin
            ball_y_n = ball_y - SPEED;
          end
        end else if (ball_y + SIZE + SPEED > Y_LIM) begin
          ball_y_n = Y_LIM - SIZE;
          dir_y_n  = DIR_UP;
        end else begin
          ball_y_n = ball_y + SPEED;
        end
        // X priority: paddle hit, then miss, then plain movement.
        if (hit_l) begin
          ball_x_n = PE;
          dir_x_n  = DIR_RIGHT;
        end else if (hit_r) begin
          ball_x_n = PR - SIZE;
          dir_x_n  = DIR_LEFT;
        end else if (miss_l) begin
          state_n       = ST_POINT;
          left_scored_n = 1'b0;
        end else if (miss_r) begin
          state_n       = ST_POINT;
          left_scored_n = 1'b1;
        end else if (dir_x == DIR_LEFT) begin
          ball_x_n = ball_x - SPEED;
        end else begin
          ball_x_n = ball_x + SPEED;
        end
      end
      ST_POINT: begin
        if (left_scored) score_l_n = score_l + SCORE_ONE;
        else             score_r_n = score_r + SCORE_ONE;
        if ((left_scored ? score_l_n : score_r_n) == WIN) begin
          state_n = ST_GAMEOVER;
        end else begin
          ball_x_n = BALL_X0;
          ball_y_n = BALL_Y0;
          dir_x_n  = left_scored ? DIR_RIGHT : DIR_LEFT;
          dir_y_n  = ~dir_y;
          state_n  = ST_SERVE;
        end
      end
      default: begin
        if (any_btn) begin
          score_l_n = '0;
          score_r_n = '0;
          ball_x_n  = BALL_X0;
          ball_y_n  = BALL_Y0;
          dir_x_n   = DIR_RIGHT;
          state_n   = ST_SERVE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_SERVE;
      ball_x      <= BALL_X0;
      ball_y      <= BALL_Y0;
      dir_x       <= DIR_RIGHT;
      dir_y       <= DIR_DOWN;
      serve_cnt   <= '0;
      score_l     <= '0;
      score_r     <= '0;
      left_scored <= 1'b0;
    end else if (frame_tick) begin
      state       <= state_n;
      ball_x      <= ball_x_n;
      ball_y      <= ball_y_n;
      dir_x       <= dir_x_n;
      dir_y       <= dir_y_n;
      serve_cnt   <= serve_cnt_n;
      score_l     <= score_l_n;
      score_r     <= score_r_n;
      left_scored <= left_scored_n;
    end
  end

  coord_t px, py;
  logic   in_ball, in_pad_l, in_pad_r;

  assign px       = {1'b0, x};
  assign py       = {1'b0, y};
  assign in_ball  = (px >= ball_x) && (px < ball_x + SIZE) &&
                    (py >= ball_y) && (py < ball_y + SIZE);
  assign in_pad_l = (px >= PL_X) && (px < PE) && (py >= pad_l) && (py < pad_l + PAD_H);
  assign in_pad_r = (px >= PR) && (px < PR + PAD_W) && (py >= pad_r) && (py < pad_r + PAD_H);

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_ball   <= 1'b0;
      pixel_paddle <= 1'b0;
    end else begin
      pixel_ball   <= in_ball && (state != ST_GAMEOVER);
      pixel_paddle <= in_pad_l || in_pad_r;
    end
  end

endmodule
